chunked_seq_adder: RTL and testbench
====================================

Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle add/subtract unit; successor to the combinational 32-bit ripple adder.
- Processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a small state machine.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Used where a full-width single-cycle carry chain is too slow or too large.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits added per clock. Must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- start  input   1      request; sampled only in IDLE
- sub    input   1      0 = x+y+cin; 1 = x-y (x + ~y + 1, cin ignored)
- cin    input   1      carry-in for add mode
- x      input   WIDTH  operand A, latched on accepted start
- y      input   WIDTH  operand B, latched on accepted start
- busy   output  1      high while chunks are being processed
- done   output  1      one-cycle pulse when the result is valid
- s      output  WIDTH  sum/difference
- cout   output  1      carry out of the MSB; in sub mode 1 = no borrow
- ovf    output  1      signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: clk and a synchronous, active-high rst. When rst is high at a clock edge:
  - state returns to IDLE;
  - busy, done, s, cout, ovf all go to 0;
  - internal operand registers, chunk index and carry are cleared.
- Reset takes priority over start and over any operation in progress. A mid-operation reset discards the operation, and no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches x and (sub ? ~y : y).
  - Carry register is loaded with (sub ? 1 : cin). Chunk index is loaded with 0.
  - Next state RUN; busy=1 from that edge.
- RUN:
  - Each edge adds chunk[idx] of A, chunk[idx] of B and carry.
  - The CHUNK-bit sum is written to s[idx*CHUNK +: CHUNK]. Carry is updated and idx increments.
  - On the edge processing idx = NCHUNK-1:
    - cout is captured;
    - ovf is computed from the MSB carry-in and carry-out;
    - next state DONE, busy=0, done=1.
- DONE: lasts one cycle. done returns to 0 at the next edge and state returns to IDLE.
- start handling outside IDLE:
  - start asserted in RUN is ignored and not queued.
  - start asserted in DONE is also ignored; the requester retries in IDLE.
- Latency: start sampled at edge E0; done is high during the cycle after edge E0+NCHUNK.
  - Default parameters: 4 RUN edges; done is visible 4 cycles after start is accepted.
  - Throughput: one result per NCHUNK+2 cycles.
- Result holding:
  - s, cout and ovf hold their values after DONE until the next accepted start.
  - While RUN is in progress, s shows partially updated chunks. Consumers use s only with done or in IDLE.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - Sub mode: cout=1 when x >= y unsigned.
  - ovf follows two's-complement rules in both modes.
- Degenerate case CHUNK=WIDTH: a single RUN cycle, done one cycle after start is accepted.
- x, y, sub and cin are don't-care outside the start-accept edge. Changes during RUN have no effect.

Test Plan:
1. Defaults, add, cin=0:
   - x=0x0000000D, y=0x00000002, start pulse → done exactly 4 cycles after acceptance.
   - s=0x0000000F, cout=0, ovf=0, busy high for exactly 4 cycles.
2. Multi-chunk carry, add:
   - x=0x0800010D, y=0x17000002 → s=0x1F00010F, cout=0, ovf=0.
   - x=0xFFFFFFFF, y=0x00000001 → s=0x00000000, cout=1, ovf=0. The carry ripples across all 4 chunks.
3. Overflow and subtract:
   - Add x=0x7FFFFFFF, y=0x00000001 → s=0x80000000, ovf=1, cout=0.
   - Sub x=0x0000000D, y=0x0000000D → s=0, cout=1, ovf=0.
   - Sub x=0x00000002, y=0x0000000D → s=0xFFFFFFF5, cout=0.
   - Sub x=0x80000000, y=0x00000001 → s=0x7FFFFFFF, ovf=1.
4. Handshake:
   - Hold start high continuously with changing x/y → each result corresponds to the operands present at its accept edge. Accept edges are spaced NCHUNK+2 cycles apart.
   - Starts asserted during RUN or DONE produce no extra done.
   - After completion, s holds its value until the next accept.
5. Reset mid-op: assert rst on the 2nd RUN cycle → next edge gives busy=0, done=0, s=0, cout=0, ovf=0. No done pulse follows. A fresh start then completes normally.
6. Parameter sweep:
   - WIDTH=16, CHUNK=4: x=0xFFFF, y=0x0001 → s=0x0000, cout=1 after 4 RUN cycles.
   - WIDTH=8, CHUNK=8: x=0x7F, y=0x01 → s=0x80, ovf=1, done 1 cycle after acceptance.

Source files
------------

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed CHUNK bits per
// clock, least significant chunk first, with a start/busy/done handshake.
// CHUNK must divide WIDTH exactly.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | waiting for start; s/cout/ovf hold the last result
// ST_RUN  | one chunk added per clock, carry rippled through carry_reg
// ST_DONE | result valid, done pulses for this single cycle
module chunked_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum_ext;
    logic             carry_next;
    logic             msb_carry_in;
    logic [WIDTH-1:0] s_next;

    // Select the operand chunks addressed by idx (constant slices keep the
    // index arithmetic out of the datapath).
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                a_chunk = a_reg[k*CHUNK +: CHUNK];
                b_chunk = b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    // One chunk of the ripple: CHUNK-bit sum plus carry out.
    assign sum_ext    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    assign carry_next = sum_ext[CHUNK];

    // Carry into the top bit recovered from sum = a ^ b ^ carry_in at that bit,
    // which also covers CHUNK = 1 without a separate low-part adder.
    assign msb_carry_in = sum_ext[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

    // Merge the freshly computed chunk into the result word.
    always_comb begin
        s_next = s;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                s_next[k*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
            end
        end
    end

    // Sequencer: accept in IDLE, ripple chunks in RUN, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= x;
                        b_reg     <= sub ? ~y : y;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s         <= s_next;
                    carry_reg <= carry_next;
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= carry_next;
                        ovf   <= carry_next ^ msb_carry_in;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: three instances (32/8, 16/4, 8/8),
// drivers push expected results, per-instance monitors pop them on done.
module tb_chunked_seq_adder;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int unsigned acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst = 1'b1;

    // 32/8 instance
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [31:0] x = '0, y = '0, s;
    logic        busy, done, cout, ovf;

    // 16/4 instance
    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0, s16;
    logic        busy16, done16, cout16, ovf16;

    // 8/8 instance
    logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0, s8;
    logic        busy8, done8, cout8, ovf8;

    exp_t q32[$];
    exp_t q16[$];
    exp_t q8[$];

    chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .x(x), .y(y),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf));

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16), .x(x16), .y(y16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16));

    chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: compare on done, count busy cycles per operation.
    int busy_cnt32 = 0, busy_cnt16 = 0, busy_cnt8 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt32++;
        if (done) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL done32_spurious: got done=1, expected no done (t=%0t)", $time);
            end else begin
                e = q32.pop_front();
                check("s32", s, e.s);
                check("cout32", {31'b0, cout}, {31'b0, e.cout});
                check("ovf32", {31'b0, ovf}, {31'b0, e.ovf});
                check("latency32", cyc - e.acc, 32'd4);
                check("busy_cycles32", busy_cnt32, 32'd4);
            end
            busy_cnt32 = 0;
        end else if (!busy) busy_cnt32 = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy16) busy_cnt16++;
        if (done16) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL done16_spurious: got done=1, expected no done (t=%0t)", $time);
            end else begin
                e = q16.pop_front();
                check("s16", {16'b0, s16}, e.s);
                check("cout16", {31'b0, cout16}, {31'b0, e.cout});
                check("ovf16", {31'b0, ovf16}, {31'b0, e.ovf});
                check("latency16", cyc - e.acc, 32'd4);
                check("busy_cycles16", busy_cnt16, 32'd4);
            end
            busy_cnt16 = 0;
        end else if (!busy16) busy_cnt16 = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy8) busy_cnt8++;
        if (done8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_spurious: got done=1, expected no done (t=%0t)", $time);
            end else begin
                e = q8.pop_front();
                check("s8", {24'b0, s8}, e.s);
                check("cout8", {31'b0, cout8}, {31'b0, e.cout});
                check("ovf8", {31'b0, ovf8}, {31'b0, e.ovf});
                check("latency8", cyc - e.acc, 32'd1);
                check("busy_cycles8", busy_cnt8, 32'd1);
            end
            busy_cnt8 = 0;
        end else if (!busy8) busy_cnt8 = 0;
    end

    // Drivers: all called at a negedge, return at a negedge.
    task automatic wait_idle32();
        int n = 0;
        while ((busy || done) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL idle32_timeout: got busy=%0b done=%0b, expected idle", busy, done);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sb,
                           input logic ci, input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        wait_idle32();
        x = a; y = b; sub = sb; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 32'hA5A5_5A5A; y = 32'h3C3C_C3C3; sub = ~sb; cin = ~ci;
        e.s = es; e.cout = ec; e.ovf = eo; e.acc = cyc;
        q32.push_back(e);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sb,
                           input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        int n = 0;
        while ((busy16 || done16) && n < 50) begin @(negedge clk); n++; end
        x16 = a; y16 = b; sub16 = sb; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; x16 = 16'h5A5A; y16 = 16'hC3C3;
        e.s = {16'b0, es}; e.cout = ec; e.ovf = eo; e.acc = cyc;
        q16.push_back(e);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                          input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int n = 0;
        while ((busy8 || done8) && n < 50) begin @(negedge clk); n++; end
        x8 = a; y8 = b; sub8 = sb; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'h5A; y8 = 8'hC3;
        e.s = {24'b0, es}; e.cout = ec; e.ovf = eo; e.acc = cyc;
        q8.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending, expected 0",
                     q32.size(), q16.size(), q8.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);

        // Directed vectors, default parameters
        issue32(32'h0000_000D, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0);
        issue32(32'h0800_010D, 32'h1700_0002, 1'b0, 1'b0, 32'h1F00_010F, 1'b0, 1'b0);
        issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        issue32(32'h0000_0010, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0016, 1'b0, 1'b0);
        issue32(32'h0000_000D, 32'h0000_000D, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue32(32'h0000_0002, 32'h0000_000D, 1'b1, 1'b0, 32'hFFFF_FFF5, 1'b0, 1'b0);
        issue32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue32(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        drain();

        // start held high with x changing every cycle: accepts at k = 0, 6, 12
        wait_idle32();
        c0 = cyc;
        for (int k = 0; k < 15; k++) begin
            exp_t e;
            x = k; y = 32'h0000_0100; sub = 1'b0; cin = 1'b0; start = 1'b1;
            if (k == 0 || k == 6 || k == 12) begin
                e.s = (k == 0) ? 32'h100 : (k == 6) ? 32'h106 : 32'h10C;
                e.cout = 1'b0; e.ovf = 1'b0; e.acc = c0 + k + 1;
                q32.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Result holds while inputs wander
        x = 32'hDEAD_BEEF; y = 32'h1234_5678;
        repeat (5) @(negedge clk);
        check("hold_s", s, 32'h0000_010C);

        // Reset during the second RUN cycle discards the operation
        wait_idle32();
        x = 32'h1111_1111; y = 32'h2222_2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_s", s, 32'd0);
        check("midrst_cout", {31'b0, cout}, 32'd0);
        check("midrst_ovf", {31'b0, ovf}, 32'd0);
        repeat (8) @(negedge clk);
        issue32(32'h0000_0021, 32'h0000_0012, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0);
        drain();

        // Parameter sweep
        issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        drain();
        repeat (10) @(negedge clk);

        check("pending_total", q32.size() + q16.size() + q8.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
